// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// Only one request is ever outstanding; responses carry no tag.
interface fetch_stage_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem fetch, IF/ID register
// with one-entry skid buffer, and redirect flush with stale-response discard.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    fetch_stage_if.master     imem,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              stall_d,
    output logic              valid_d,
    output logic [31:0]       instr_d,
    output logic [31:0]       pc_d,
    output logic [31:0]       pc_plus4_d,
    output logic [6:0]        op_d,
    output logic [2:0]        funct3_d,
    output logic [6:0]        funct7_d
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] pc_req_q, pc_req_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        req_valid;
    logic        deliver;
    logic        ifid_free;
    logic [31:0] redirect_tgt;

    assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
    assign ifid_free           = ~ifid_valid_q | ~stall_d;
    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = pc_f_q;

    always_comb begin
        state_d   = state_q;
        pc_f_d    = pc_f_q;
        pc_req_d  = pc_req_q;
        req_valid = 1'b0;
        deliver   = 1'b0;

        case (state_q)
            ST_REQ: begin
                req_valid = ~rst & ~skid_valid_q & ~redirect_valid;
                if (redirect_valid) begin
                    pc_f_d = redirect_tgt;
                end else if (req_valid && imem.imem_req_ready) begin
                    pc_f_d   = pc_f_q + 32'd4;
                    pc_req_d = pc_f_q;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_f_d  = redirect_tgt;
                    state_d = imem.imem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (imem.imem_rsp_valid) begin
                    deliver = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (redirect_valid) begin
                    pc_f_d = redirect_tgt;
                end
                if (imem.imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    // IF/ID and skid: flush beats skid drain beats fresh delivery.
    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (redirect_valid) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_valid_d = 1'b0;
        end else if (ifid_free && skid_valid_q) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = skid_instr_q;
            ifid_pc_d    = skid_pc_q;
            ifid_pc4_d   = skid_pc_q + 32'd4;
            skid_valid_d = 1'b0;
        end else if (ifid_free && deliver) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = imem.imem_rsp_data;
            ifid_pc_d    = pc_req_q;
            ifid_pc4_d   = pc_req_q + 32'd4;
        end else if (ifid_free) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (deliver) begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem.imem_rsp_data;
            skid_pc_d    = pc_req_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_f_q       <= RESET_PC;
            pc_req_q     <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            pc_req_q     <= pc_req_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign valid_d    = ifid_valid_q;
    assign instr_d    = ifid_instr_q;
    assign pc_d       = ifid_pc_q;
    assign pc_plus4_d = ifid_pc4_q;
    assign op_d       = ifid_instr_q[6:0];
    assign funct3_d   = ifid_instr_q[14:12];
    assign funct7_d   = ifid_instr_q[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized traffic, all
// checked against an in-order instruction-stream model and a one-outstanding imem.
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic [6:0]  op_d;
    logic [2:0]  funct3_d;
    logic [6:0]  funct7_d;

    fetch_stage_if imem_if ();

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem_if),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_d        (stall_d),
        .valid_d        (valid_d),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pc_plus4_d     (pc_plus4_d),
        .op_d           (op_d),
        .funct3_d       (funct3_d),
        .funct7_d       (funct7_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_pc;
    int          consumed;
    bit          pending;
    int          lat_cnt;
    int          lat_fixed;
    int          ready_mode;
    logic [31:0] mem_addr;
    bit          hold_prev;
    logic [31:0] hold_addr;

    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h0010_0113;
            32'h8:   return 32'h0020_81B3;
            32'hC:   return 32'h4030_8233;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Drive memory for this cycle, then sample at the falling edge and update the model.
    task automatic open_cycle();
        logic [31:0] w;
        if (rst) begin
            pending = 1'b0;
            imem_if.imem_rsp_valid = 1'b0;
            imem_if.imem_rsp_data  = $urandom;
        end else if (pending && lat_cnt == 0) begin
            imem_if.imem_rsp_valid = 1'b1;
            imem_if.imem_rsp_data  = memword(mem_addr);
        end else begin
            imem_if.imem_rsp_valid = 1'b0;
            imem_if.imem_rsp_data  = $urandom;
            if (pending) lat_cnt--;
        end
        case (ready_mode)
            0:       imem_if.imem_req_ready = 1'b1;
            2:       imem_if.imem_req_ready = 1'b0;
            default: imem_if.imem_req_ready = ($urandom_range(0, 3) != 0);
        endcase

        @(negedge clk);

        if (rst) begin
            exp_pc    = RESET_PC;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && !redirect_valid) begin
                chk("req_hold_valid", imem_if.imem_req_valid, 1);
                chk("req_hold_addr", imem_if.imem_req_addr, hold_addr);
            end
            if (imem_if.imem_req_valid) begin
                chk("req_single_outstanding", pending, 0);
                chk("req_addr_align", imem_if.imem_req_addr[1:0], 0);
            end
            if (redirect_valid) begin
                chk("redirect_no_req", imem_if.imem_req_valid, 0);
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (valid_d && !stall_d) begin
                w = memword(exp_pc);
                chk("consume_pc", pc_d, exp_pc);
                chk("consume_instr", instr_d, w);
                chk("consume_pc_plus4", pc_plus4_d, exp_pc + 32'd4);
                chk("consume_op", op_d, w[6:0]);
                chk("consume_funct3", funct3_d, w[14:12]);
                chk("consume_funct7", funct7_d, w[31:25]);
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (!valid_d) chk("empty_is_nop", instr_d, NOP);
            if (imem_if.imem_rsp_valid) pending = 1'b0;
            if (imem_if.imem_req_valid && imem_if.imem_req_ready) begin
                pending  = 1'b1;
                mem_addr = imem_if.imem_req_addr;
                lat_cnt  = (lat_fixed != 0) ? lat_fixed - 1 : int'($urandom_range(0, 2));
            end
            hold_prev = imem_if.imem_req_valid && !imem_if.imem_req_ready;
            hold_addr = imem_if.imem_req_addr;
        end
    endtask

    task automatic close_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_cycle();
        open_cycle();
        close_cycle();
    endtask

    initial begin
        int start;
        int unsigned n;

        rst = 1'b1; stall_d = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_if.imem_req_ready = 1'b0; imem_if.imem_rsp_valid = 1'b0; imem_if.imem_rsp_data = '0;
        exp_pc = RESET_PC; consumed = 0; pending = 1'b0; lat_cnt = 0;
        lat_fixed = 1; ready_mode = 0; mem_addr = '0; hold_prev = 1'b0; hold_addr = '0;

        quiet_cycle();
        open_cycle();
        chk("rst_req_valid", imem_if.imem_req_valid, 0);
        chk("rst_req_addr", imem_if.imem_req_addr, RESET_PC);
        chk("rst_valid_d", valid_d, 0);
        chk("rst_instr_d", instr_d, NOP);
        chk("rst_pc_d", pc_d, 0);
        chk("rst_pc_plus4_d", pc_plus4_d, 0);
        chk("rst_op_d", op_d, 7'h13);
        chk("rst_funct3_d", funct3_d, 0);
        chk("rst_funct7_d", funct7_d, 0);
        close_cycle();
        rst = 1'b0;

        // Straight-line fetch, zero-wait memory.
        open_cycle();
        chk("first_req_valid", imem_if.imem_req_valid, 1);
        chk("first_req_addr", imem_if.imem_req_addr, 32'h0);
        close_cycle();
        open_cycle();
        chk("wait_no_req", imem_if.imem_req_valid, 0);
        chk("latency_not_yet", valid_d, 0);
        close_cycle();
        open_cycle();
        chk("latency_valid_d", valid_d, 1);
        chk("first_instr_d", instr_d, 32'h0050_0093);
        chk("first_pc_d", pc_d, 32'h0);
        chk("first_pc_plus4_d", pc_plus4_d, 32'h4);
        chk("first_op_d", op_d, 7'h13);
        chk("second_req_addr", imem_if.imem_req_addr, 32'h4);
        close_cycle();
        open_cycle();
        chk("half_rate_gap", valid_d, 0);
        close_cycle();

        // Decode back-pressure fills the skid.
        stall_d = 1'b1;
        open_cycle();
        chk("bp_pc_d", pc_d, 32'h4);
        chk("bp_req_addr", imem_if.imem_req_addr, 32'h8);
        close_cycle();
        quiet_cycle();
        for (int unsigned i = 0; i < 3; i++) begin
            open_cycle();
            chk("bp_req_gated", imem_if.imem_req_valid, 0);
            chk("bp_pc_hold", pc_d, 32'h4);
            chk("bp_valid_hold", valid_d, 1);
            close_cycle();
        end
        stall_d = 1'b0;
        open_cycle();
        chk("bp_drain_gated", imem_if.imem_req_valid, 0);
        chk("bp_release_pc", pc_d, 32'h4);
        close_cycle();
        open_cycle();
        chk("bp_skid_pc", pc_d, 32'h8);
        chk("bp_next_req_addr", imem_if.imem_req_addr, 32'hC);
        close_cycle();
        quiet_cycle();
        lat_fixed = 2;
        open_cycle();
        chk("bp_last_pc", pc_d, 32'hC);
        close_cycle();
        lat_fixed = 1;

        // Redirect while waiting with no response: stale word dropped.
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        quiet_cycle();
        redirect_valid = 1'b0;
        open_cycle();
        chk("drop_valid_d", valid_d, 0);
        chk("drop_no_req", imem_if.imem_req_valid, 0);
        close_cycle();
        open_cycle();
        chk("drop_req_valid", imem_if.imem_req_valid, 1);
        chk("drop_req_addr", imem_if.imem_req_addr, 32'h100);
        close_cycle();
        quiet_cycle();
        stall_d = 1'b1;
        open_cycle();
        chk("drop_target_pc", pc_d, 32'h100);
        chk("drop_target_valid", valid_d, 1);
        close_cycle();

        // Redirect coincident with response under stall.
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        quiet_cycle();
        redirect_valid = 1'b0; stall_d = 1'b0;
        open_cycle();
        chk("flush_valid_d", valid_d, 0);
        chk("flush_instr_d", instr_d, NOP);
        chk("flush_req_valid", imem_if.imem_req_valid, 1);
        chk("flush_req_addr", imem_if.imem_req_addr, 32'h100);
        close_cycle();

        // PC wrap with ready held low.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        quiet_cycle();
        redirect_valid = 1'b0; ready_mode = 2;
        for (int unsigned i = 0; i < 3; i++) begin
            open_cycle();
            chk("wrap_hold_valid", imem_if.imem_req_valid, 1);
            chk("wrap_hold_addr", imem_if.imem_req_addr, 32'hFFFF_FFF8);
            close_cycle();
        end
        ready_mode = 0;
        quiet_cycle();
        quiet_cycle();
        open_cycle();
        chk("wrap_pc_d0", pc_d, 32'hFFFF_FFF8);
        chk("wrap_req_addr1", imem_if.imem_req_addr, 32'hFFFF_FFFC);
        close_cycle();
        quiet_cycle();
        open_cycle();
        chk("wrap_pc_d1", pc_d, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4_d, 32'h0);
        chk("wrap_req_addr2", imem_if.imem_req_addr, 32'h0);
        close_cycle();

        // Synchronous reset while a request is outstanding.
        rst = 1'b1;
        quiet_cycle();
        rst = 1'b0;
        open_cycle();
        chk("mid_rst_valid_d", valid_d, 0);
        chk("mid_rst_req_valid", imem_if.imem_req_valid, 1);
        chk("mid_rst_req_addr", imem_if.imem_req_addr, RESET_PC);
        close_cycle();

        // Randomized traffic.
        ready_mode = 1; lat_fixed = 0;
        for (int unsigned i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 299) == 0);
            stall_d        = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 1) == 1) ? 32'($urandom)
                                                         : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            quiet_cycle();
        end

        rst = 1'b0; stall_d = 1'b0; redirect_valid = 1'b0; ready_mode = 0; lat_fixed = 1;
        start = consumed;
        n = 0;
        while (consumed == start && n < 20) begin
            quiet_cycle();
            n++;
        end
        chk("drain_progress", (consumed > start) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
